// File: rtl/demux_1x4_route.sv
// -----------------------------------------------------------------------------
// demux_1x4_route
//   Routes a single word stream to one of four output lanes. The lane is
//   selected by a 2-bit destination field embedded in the word, which is
//   forwarded unmodified. A one-word hold register absorbs a word whose
//   destination lane reports full; while it is occupied the upstream is
//   throttled through ready_out. A per-lane counter tracks delivered words.
//
// Ports
//   clk                 rising-edge clock
//   reset_L             asynchronous active-low reset
//   data_in[DATA_SIZE]  word from upstream
//   valid_in            data_in carries a word this cycle
//   ready_out           block accepts data_in this cycle (upstream pop)
//   full0..full3        downstream lane N cannot take a word this cycle
//   data_out0..3        lane N data, holds its last value between pulses
//   valid_out0..3       lane N one-cycle delivery pulse
//   cnt0..cnt3          words delivered on lane N, wraps modulo 2^COUNT_W
// -----------------------------------------------------------------------------
module demux_1x4_route #(
    parameter int DATA_SIZE = 12,
    parameter int DEST_LSB  = 10,
    parameter int COUNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic [DATA_SIZE-1:0] data_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    input  logic                 full0,
    input  logic                 full1,
    input  logic                 full2,
    input  logic                 full3,
    output logic [DATA_SIZE-1:0] data_out0,
    output logic [DATA_SIZE-1:0] data_out1,
    output logic [DATA_SIZE-1:0] data_out2,
    output logic [DATA_SIZE-1:0] data_out3,
    output logic                 valid_out0,
    output logic                 valid_out1,
    output logic                 valid_out2,
    output logic                 valid_out3,
    output logic [COUNT_W-1:0]   cnt0,
    output logic [COUNT_W-1:0]   cnt1,
    output logic [COUNT_W-1:0]   cnt2,
    output logic [COUNT_W-1:0]   cnt3
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_SIZE-1:0]   hold_word_q, hold_word_d;
    logic [1:0]             hold_dest_q, hold_dest_d;

    logic [3:0]             full_vec;
    logic [1:0]             in_dest;
    logic                   accept;

    // Single delivery request shared by all lanes: at most one lane fires.
    logic                   deliver_en;
    logic [1:0]             deliver_lane;
    logic [DATA_SIZE-1:0]   deliver_word;

    assign full_vec  = {full3, full2, full1, full0};
    assign in_dest   = data_in[DEST_LSB+1:DEST_LSB];
    // Depends only on state (and reset), never on valid_in.
    assign ready_out = reset_L && (state_q == IDLE);
    assign accept    = valid_in && ready_out;

    always_comb begin
        state_d      = state_q;
        hold_word_d  = hold_word_q;
        hold_dest_d  = hold_dest_q;
        deliver_en   = 1'b0;
        deliver_lane = in_dest;
        deliver_word = data_in;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (full_vec[in_dest]) begin
                        hold_word_d = data_in;
                        hold_dest_d = in_dest;
                        state_d     = HOLD;
                    end else begin
                        deliver_en = 1'b1;
                    end
                end
            end
            HOLD: begin
                // Only the held word's own lane matters; no timeout.
                deliver_lane = hold_dest_q;
                deliver_word = hold_word_q;
                if (!full_vec[hold_dest_q]) begin
                    deliver_en = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= IDLE;
            hold_word_q <= '0;
            hold_dest_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_word_q <= hold_word_d;
            hold_dest_q <= hold_dest_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic                 hit;
            logic [DATA_SIZE-1:0] data_out_q;
            logic                 valid_out_q;
            logic [COUNT_W-1:0]   cnt_q;

            assign hit = deliver_en && (deliver_lane == 2'(gi));

            always_ff @(posedge clk or negedge reset_L) begin
                if (!reset_L) begin
                    data_out_q  <= '0;
                    valid_out_q <= 1'b0;
                    cnt_q       <= '0;
                end else begin
                    valid_out_q <= hit;
                    if (hit) begin
                        data_out_q <= deliver_word;
                        cnt_q      <= cnt_q + COUNT_W'(1);
                    end
                end
            end
        end
    endgenerate

    assign data_out0  = g_lane[0].data_out_q;
    assign data_out1  = g_lane[1].data_out_q;
    assign data_out2  = g_lane[2].data_out_q;
    assign data_out3  = g_lane[3].data_out_q;
    assign valid_out0 = g_lane[0].valid_out_q;
    assign valid_out1 = g_lane[1].valid_out_q;
    assign valid_out2 = g_lane[2].valid_out_q;
    assign valid_out3 = g_lane[3].valid_out_q;
    assign cnt0       = g_lane[0].cnt_q;
    assign cnt1       = g_lane[1].cnt_q;
    assign cnt2       = g_lane[2].cnt_q;
    assign cnt3       = g_lane[3].cnt_q;

endmodule

// File: tb/tb_demux_1x4_route.sv
// -----------------------------------------------------------------------------
// tb_demux_1x4_route
//   Directed stimulus for demux_1x4_route. A behavioural model (one pending
//   slot plus per-lane expected data/pulse/count) is compared against every
//   DUT output on each falling edge outside reset; hand-computed literal
//   checks pin the model at key points of each scenario.
// -----------------------------------------------------------------------------
module tb_demux_1x4_route;

    localparam int DW = 12;
    localparam int DL = 10;
    localparam int CW = 8;

    logic          clk;
    logic          reset_L;
    logic [DW-1:0] data_in;
    logic          valid_in;
    logic          ready_out;
    logic [3:0]    full;
    logic [DW-1:0] data_out0, data_out1, data_out2, data_out3;
    logic          valid_out0, valid_out1, valid_out2, valid_out3;
    logic [CW-1:0] cnt0, cnt1, cnt2, cnt3;

    int n_vec;
    int n_bad;

    demux_1x4_route #(.DATA_SIZE(DW), .DEST_LSB(DL), .COUNT_W(CW)) dut (
        .clk(clk), .reset_L(reset_L),
        .data_in(data_in), .valid_in(valid_in), .ready_out(ready_out),
        .full0(full[0]), .full1(full[1]), .full2(full[2]), .full3(full[3]),
        .data_out0(data_out0), .data_out1(data_out1),
        .data_out2(data_out2), .data_out3(data_out3),
        .valid_out0(valid_out0), .valid_out1(valid_out1),
        .valid_out2(valid_out2), .valid_out3(valid_out3),
        .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane views of the DUT outputs for indexed comparison.
    logic [DW-1:0] dout [4];
    logic          vout [4];
    logic [CW-1:0] cout [4];
    assign dout[0] = data_out0;  assign dout[1] = data_out1;
    assign dout[2] = data_out2;  assign dout[3] = data_out3;
    assign vout[0] = valid_out0; assign vout[1] = valid_out1;
    assign vout[2] = valid_out2; assign vout[3] = valid_out3;
    assign cout[0] = cnt0;       assign cout[1] = cnt1;
    assign cout[2] = cnt2;       assign cout[3] = cnt3;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int dest_of(input logic [DW-1:0] w);
        return int'(w[DL+1:DL]);
    endfunction

    // ---------------- behavioural model ----------------
    // A word waits in the pending slot whenever its lane is full; the
    // upstream is served only while the slot is empty.
    logic          m_pend_valid, n_pend_valid;
    logic [DW-1:0] m_pend_word,  n_pend_word;
    logic [DW-1:0] m_data [4];
    logic [DW-1:0] n_data [4];
    logic          m_valid [4];
    logic          n_valid [4];
    int            m_cnt [4];
    int            n_cnt [4];
    logic          hit;
    logic [DW-1:0] hit_word;
    int            hit_lane;

    always_comb begin
        n_pend_valid = m_pend_valid;
        n_pend_word  = m_pend_word;
        hit          = 1'b0;
        hit_word     = '0;
        hit_lane     = 0;
        for (int i = 0; i < 4; i++) begin
            n_data[i]  = m_data[i];
            n_valid[i] = 1'b0;
            n_cnt[i]   = m_cnt[i];
        end
        if (m_pend_valid) begin
            if (!full[dest_of(m_pend_word)]) begin
                hit          = 1'b1;
                hit_word     = m_pend_word;
                n_pend_valid = 1'b0;
            end
        end else if (valid_in) begin
            if (full[dest_of(data_in)]) begin
                n_pend_valid = 1'b1;
                n_pend_word  = data_in;
            end else begin
                hit      = 1'b1;
                hit_word = data_in;
            end
        end
        if (hit) begin
            hit_lane          = dest_of(hit_word);
            n_valid[hit_lane] = 1'b1;
            n_data[hit_lane]  = hit_word;
            n_cnt[hit_lane]   = (m_cnt[hit_lane] + 1) % 256;
        end
    end

    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            m_pend_valid <= 1'b0;
            m_pend_word  <= '0;
            for (int i = 0; i < 4; i++) begin
                m_data[i]  <= '0;
                m_valid[i] <= 1'b0;
                m_cnt[i]   <= 0;
            end
        end else begin
            m_pend_valid <= n_pend_valid;
            m_pend_word  <= n_pend_word;
            for (int i = 0; i < 4; i++) begin
                m_data[i]  <= n_data[i];
                m_valid[i] <= n_valid[i];
                m_cnt[i]   <= n_cnt[i];
            end
        end
    end

    // ---------------- every-cycle compare ----------------
    always @(negedge clk) begin
        if (reset_L === 1'b1) begin
            chk("ready_out", int'(ready_out), int'(!m_pend_valid));
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("valid_out%0d", i), int'(vout[i]), int'(m_valid[i]));
                chk($sformatf("data_out%0d", i),  int'(dout[i]), int'(m_data[i]));
                chk($sformatf("cnt%0d", i),       int'(cout[i]), m_cnt[i]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] w);
        valid_in = v;
        data_in  = w;
    endtask

    logic [DW-1:0] t2_words [4];

    initial begin
        n_vec    = 0;
        n_bad    = 0;
        reset_L  = 1'b0;
        data_in  = '0;
        valid_in = 1'b0;
        full     = 4'b0000;
        t2_words[0] = 12'h0AB; t2_words[1] = 12'h4CD;
        t2_words[2] = 12'h8EF; t2_words[3] = 12'hC12;

        // 1. reset release with no traffic
        tick(); tick(); tick();
        reset_L = 1'b1;
        tick();
        $display("T1 reset release: ready=%0d", ready_out);
        chk("t1_ready", int'(ready_out), 1);
        chk("t1_cnt0", int'(cnt0), 0);
        chk("t1_dout3", int'(data_out3), 0);

        // 2. back-to-back words, one per lane
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, t2_words[i]);
            tick();
            $display("T2 word 0x%03h -> lane %0d", t2_words[i], i);
            chk($sformatf("t2_pulse%0d", i), int'(vout[i]), 1);
        end
        drive(1'b0, '0);
        tick();
        chk("t2_dout0", int'(data_out0), 'h0AB);
        chk("t2_dout1", int'(data_out1), 'h4CD);
        chk("t2_dout2", int'(data_out2), 'h8EF);
        chk("t2_dout3", int'(data_out3), 'hC12);
        for (int i = 0; i < 4; i++) chk($sformatf("t2_cnt%0d", i), int'(cout[i]), 1);

        // 3. stall on lane 2, then a queued word to lane 0
        full = 4'b0100;
        drive(1'b1, 12'h855);
        tick();
        chk("t3_ready_e0", int'(ready_out), 0);
        drive(1'b1, 12'h003);
        tick();
        chk("t3_ready_e1", int'(ready_out), 0);
        chk("t3_nopulse2", int'(valid_out2), 0);
        tick();
        chk("t3_ready_e2", int'(ready_out), 0);
        full = 4'b0000;
        tick();
        $display("T3 held word released: lane2 0x%03h", data_out2);
        chk("t3_pulse2", int'(valid_out2), 1);
        chk("t3_dout2", int'(data_out2), 'h855);
        chk("t3_nopulse0", int'(valid_out0), 0);
        chk("t3_ready_back", int'(ready_out), 1);
        tick();
        $display("T3 second word: lane0 0x%03h", data_out0);
        chk("t3_pulse0", int'(valid_out0), 1);
        chk("t3_dout0", int'(data_out0), 'h003);
        drive(1'b0, '0);
        tick();

        // 4. full1 high while streaming lane-0 words
        full = 4'b0010;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 12'(i));
            tick();
            $display("T4 lane0 word 0x%03h", 12'(i));
            chk("t4_ready", int'(ready_out), 1);
            chk("t4_dout0", int'(data_out0), i);
        end
        drive(1'b0, '0);
        full = 4'b0000;
        tick();
        chk("t4_cnt0", int'(cnt0), 7);

        // 5. reset while a lane-1 word is held
        full = 4'b0010;
        drive(1'b1, 12'h4FF);
        tick();
        drive(1'b0, '0);
        tick();
        chk("t5_held", int'(ready_out), 0);
        reset_L = 1'b0;
        #1;
        chk("t5_rst_ready", int'(ready_out), 0);
        chk("t5_rst_cnt1", int'(cnt1), 0);
        tick(); tick();
        reset_L = 1'b1;
        full = 4'b0000;
        tick(); tick(); tick();
        $display("T5 after reset: cnt1=%0d", cnt1);
        chk("t5_cnt1", int'(cnt1), 0);
        chk("t5_dout1", int'(data_out1), 0);

        // 6. 256 words to lane 3: counter wraps
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 12'hC00 | 12'(i));
            tick();
            if (i == 0) chk("t6_cnt3_first", int'(cnt3), 1);
        end
        drive(1'b0, '0);
        tick();
        $display("T6 256 words to lane3: cnt3=%0d", cnt3);
        chk("t6_cnt3_wrap", int'(cnt3), 0);
        chk("t6_dout3", int'(data_out3), 'hCFF);
        chk("t6_cnt0", int'(cnt0), 0);
        chk("t6_cnt2", int'(cnt2), 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
